// File: rtl/pmod_da2_serializer.sv
// PMOD-DA2 dual-DAC frame serializer with one-word holding register.
// Ports: clk_selected/reset (async high), enable, clkdiv, sample_* handshake,
//        sclk/sync_n/dina/dinb pins, frame_strobe, busy, underrun_count.
module pmod_da2_serializer #(
  parameter int FRAME_SCLKS    = 32,
  parameter int UNDERRUN_WIDTH = 16
) (
  input  logic                      clk_selected,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [2:0]                clkdiv,
  input  logic [31:0]               sample_data,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      sclk,
  output logic                      sync_n,
  output logic                      dina,
  output logic                      dinb,
  output logic                      frame_strobe,
  output logic                      busy,
  output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [6:0] LAST_H = 7'(2 * FRAME_SCLKS - 1);
  localparam logic [UNDERRUN_WIDTH-1:0] SAT = {UNDERRUN_WIDTH{1'b1}};

  state_t      state, state_nx;
  logic [6:0]  pre;
  logic [6:0]  h;
  logic [6:0]  hn;
  logic [6:0]  pre_max;
  logic [2:0]  div;
  logic [15:0] hold_a, hold_b;
  logic [15:0] sh_a, sh_b;
  logic [15:0] word_a, word_b;
  logic        full;
  logic        accept;
  logic        hp_end;
  logic        last;
  logic        start;
  logic        sclk_nx, sync_nx, dina_nx, dinb_nx;
  logic        unused;

  assign unused = ^{sample_data[3:0], sample_data[19:16]};

  assign sample_ready = ~full;
  assign accept       = sample_valid & ~full;
  assign busy         = (state == FRAME);
  assign frame_strobe = (state == FRAME) && (h == 7'd0)
                        && (pre == 7'd0);

  // div=7 wraps the shift to zero, giving 127 as intended
  assign pre_max = (7'd1 << div) - 7'd1;
  assign hp_end  = (pre == pre_max);
  assign last    = (state == FRAME) && hp_end && (h == LAST_H);
  assign start   = enable && ((state == IDLE) || last);
  assign hn      = h + 7'd1;

  // word loaded at frame start: held word, else bypass, else resend
  always_comb begin
    word_a = sh_a;
    word_b = sh_b;
    if (full) begin
      word_a = hold_a;
      word_b = hold_b;
    end else if (accept) begin
      word_a = {4'b0000, sample_data[15:4]};
      word_b = {4'b0000, sample_data[31:20]};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (enable) state_nx = FRAME;
      FRAME: if (last && !enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // pins are computed one cycle ahead so they all switch together
  always_comb begin
    sclk_nx = sclk;
    sync_nx = sync_n;
    dina_nx = dina;
    dinb_nx = dinb;
    if (start) begin
      sclk_nx = 1'b1;
      sync_nx = 1'b0;
      dina_nx = word_a[15];
      dinb_nx = word_b[15];
    end else if (state == IDLE || last) begin
      sclk_nx = 1'b1;
      sync_nx = 1'b1;
      dina_nx = 1'b0;
      dinb_nx = 1'b0;
    end else if (hp_end) begin
      sclk_nx = ~hn[0];
      if (hn >= 7'd32) begin
        sync_nx = 1'b1;
        dina_nx = 1'b0;
        dinb_nx = 1'b0;
      end else if (!hn[0]) begin
        sync_nx = 1'b0;
        dina_nx = sh_a[4'd15 - hn[4:1]];
        dinb_nx = sh_b[4'd15 - hn[4:1]];
      end
    end
  end

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      sclk   <= 1'b1;
      sync_n <= 1'b1;
      dina   <= 1'b0;
      dinb   <= 1'b0;
    end else begin
      sclk   <= sclk_nx;
      sync_n <= sync_nx;
      dina   <= dina_nx;
      dinb   <= dinb_nx;
    end
  end

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      pre <= '0;
      h   <= '0;
      div <= '0;
    end else if (start) begin
      pre <= '0;
      h   <= '0;
      div <= clkdiv;
    end else if (state == FRAME) begin
      if (hp_end) begin
        pre <= '0;
        h   <= last ? 7'd0 : hn;
      end else begin
        pre <= pre + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_selected or posedge reset) begin
    if (reset) begin
      full           <= 1'b0;
      hold_a         <= '0;
      hold_b         <= '0;
      sh_a           <= '0;
      sh_b           <= '0;
      underrun_count <= '0;
    end else begin
      if (start) begin
        full <= 1'b0;
        sh_a <= word_a;
        sh_b <= word_b;
        if (!full && !accept && underrun_count != SAT)
          underrun_count <= underrun_count + 1'b1;
      end else if (accept) begin
        full   <= 1'b1;
        hold_a <= {4'b0000, sample_data[15:4]};
        hold_b <= {4'b0000, sample_data[31:20]};
      end
    end
  end

endmodule
